uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- 8N1 UART receiver for the soc serial input; the board's rx pin feeds it directly.
- Samples the asynchronous line at mid-bit using a clock-derived bit counter.
- Holds one received byte in a valid/ready register for the soc bus/CPU side.
- Flags framing errors and overruns.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
BAUD, 115200, line rate in bit/s
CLKS_PER_BIT, CLK_FREQ/BAUD (integer division, 434 at defaults), clocks per bit; must be >= 4

Ports:
clk  input  1  system clock, all logic on rising edge
resetn  input  1  asynchronous active-low reset
rx  input  1  serial line, idle high, asynchronous to clk
rx_data  output  8  received byte, valid while rx_valid=1
rx_valid  output  1  holding register full
rx_ready  input  1  consumer accepts byte when rx_valid & rx_ready
frame_err  output  1  sticky: stop bit sampled low
overrun  output  1  sticky: byte completed while holding register full and not being consumed
err_clr  input  1  one-cycle pulse clears frame_err and overrun

Behaviour:
- Reset (resetn=0, async):
  - Synchronizer flops = 1, state=IDLE, counters=0.
  - rx_data=8'h00, rx_valid=0, frame_err=0, overrun=0.
- Input sync: 2-flop synchronizer gives rx_s. All decisions use rx_s only.
- Bit counter: cnt counts down, and a sample event occurs when cnt==0. Bit index bidx is 0..7.
- IDLE:
  - When rx_s==0, load cnt=CLKS_PER_BIT/2-1 and go to START.
- START:
  - At the sample event with rx_s==0: load cnt=CLKS_PER_BIT-1, bidx=0, go to DATA.
  - At the sample event with rx_s==1: glitch; return to IDLE with no flags.
- DATA:
  - At each sample event, shift rx_s into the shift register, LSB first, and reload cnt=CLKS_PER_BIT-1.
  - After bit 7 is sampled, go to STOP.
- STOP:
  - At the sample event with rx_s==1: deliver the byte and go to IDLE.
  - At the sample event with rx_s==0: set frame_err, discard the byte, go to WAIT_IDLE.
- WAIT_IDLE:
  - Stay until rx_s==1, then go to IDLE. A break condition therefore produces one frame_err and no bytes.
- Deliver (one cycle, the stop-sample cycle):
  - Holding register empty, or consumed in that same cycle: rx_data <= byte and rx_valid=1 from the next cycle. A simultaneous consume plus deliver keeps rx_valid=1 with the new data and no overrun.
  - Holding register full and not consumed: new byte dropped, rx_data unchanged, overrun set.
- Consume: when rx_valid & rx_ready and no delivery, rx_valid=0 next cycle. rx_data keeps its value.
- rx_ready while rx_valid=0 is ignored.
- err_clr:
  - Clears both flags next cycle.
  - If a flag-setting event happens in the same cycle, set wins.
- Timing:
  - Data bit k is sampled CLKS_PER_BIT/2 + (k+1)*CLKS_PER_BIT cycles after the START entry.
  - rx_valid rises 1 cycle after the stop sample.
  - START entry is 2–3 clk after the pin falling edge, due to the synchronizer.
- Back-to-back frames: IDLE is re-entered at mid-stop-bit, so a start bit following immediately is caught. Tolerates about ±4% baud mismatch.
- A start edge during any state other than IDLE is ignored.
- Reset mid-frame aborts the frame immediately. After release, the receiver resynchronizes on the next high-to-low transition seen from IDLE.

Test Plan (CLK_FREQ=1000, BAUD=100, so CLKS_PER_BIT=10; bit period 10 clk):
- Send 0xA5 (start, 1,0,1,0,0,1,0,1, stop), rx_ready=0 -> rx_valid=1 with rx_data=0xA5 about 97 clk after the start edge; frame_err=0, overrun=0; rx_valid stays 1.
- Pulse rx_ready for 1 cycle -> rx_valid=0 next cycle. Then send 0x3C and 0xFF back-to-back, consuming each on rx_valid -> two deliveries, 0x3C then 0xFF, no flags.
- Send 0x11 then 0x22 with rx_ready=0 throughout -> rx_data=0x11, overrun=1, rx_valid=1. Pulse err_clr -> overrun=0, rx_data still 0x11.
- Send 0x55 with the stop bit low, then hold rx low 30 clk -> frame_err=1, rx_valid unchanged. Then rx high and send 0x0F -> rx_data=0x0F.
- Drive a 3-clk low glitch on idle rx -> no rx_valid, no flags, state back in IDLE.
- Assert resetn=0 during bit 4 of a frame -> all outputs return to reset values immediately. After release, a clean 0x81 frame gives rx_data=0x81.

Source files
------------

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - consumer-side bundle of the uart_rx holding register and error flags
//   rx_data   : received byte, valid while rx_valid=1
//   rx_valid  : holding register full
//   rx_ready  : consumer accepts the byte when rx_valid & rx_ready
//   frame_err : sticky, stop bit sampled low
//   overrun   : sticky, byte completed while the holding register was full and not consumed
//   err_clr   : one-cycle pulse clearing frame_err and overrun
interface uart_rx_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
    logic       err_clr;

    modport master (
        output rx_data,
        output rx_valid,
        output frame_err,
        output overrun,
        input  rx_ready,
        input  err_clr
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  overrun,
        output rx_ready,
        output err_clr
    );
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with mid-bit sampling, one-byte holding register and sticky error flags
//   clk    : system clock, rising edge
//   resetn : asynchronous active-low reset
//   rx     : serial line, idle high, asynchronous to clk
//   bus    : uart_rx_if.master (rx_data/rx_valid/rx_ready, frame_err, overrun, err_clr)
module uart_rx #(
    parameter int CLK_FREQ     = 50000000,
    parameter int BAUD         = 115200,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       rx,
    uart_rx_if.master  bus
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bidx, bidx_n;
    logic [7:0]    shreg, shreg_n;
    logic          rx_m, rx_s;
    logic          sample;
    logic          deliver;
    logic          frame_set;

    logic [7:0]    data_q;
    logic          valid_q;
    logic          ferr_q;
    logic          ovr_q;
    logic          take;
    logic          ovr_set;

    // Two-flop synchronizer; reset to the idle level so reset never looks like a start edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            cnt   <= '0;
            bidx  <= '0;
            shreg <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            bidx  <= bidx_n;
            shreg <= shreg_n;
        end
    end

    assign sample = (cnt == '0);

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bidx_n    = bidx;
        shreg_n   = shreg;
        deliver   = 1'b0;
        frame_set = 1'b0;
        unique case (state)
            IDLE: begin
                if (!rx_s) begin
                    cnt_n   = HALF;
                    state_n = START;
                end
            end
            START: begin
                if (!sample) begin
                    cnt_n = cnt - 1'b1;
                end else if (!rx_s) begin
                    cnt_n   = FULL;
                    bidx_n  = '0;
                    state_n = DATA;
                end else begin
                    // Start bit gone high at its centre: treat as a glitch.
                    state_n = IDLE;
                end
            end
            DATA: begin
                if (!sample) begin
                    cnt_n = cnt - 1'b1;
                end else begin
                    shreg_n = {rx_s, shreg[7:1]};
                    cnt_n   = FULL;
                    bidx_n  = 3'(bidx + 3'd1);
                    if (bidx == 3'd7) begin
                        state_n = STOP;
                    end
                end
            end
            STOP: begin
                if (!sample) begin
                    cnt_n = cnt - 1'b1;
                end else if (rx_s) begin
                    // Back to IDLE at mid-stop-bit so an immediately following start is caught.
                    deliver = 1'b1;
                    state_n = IDLE;
                end else begin
                    frame_set = 1'b1;
                    state_n   = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                // A held-low line (break) must not be mistaken for further start bits.
                if (rx_s) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign take    = valid_q & bus.rx_ready;
    assign ovr_set = deliver & valid_q & ~bus.rx_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            if (deliver && !ovr_set) begin
                data_q  <= shreg;
                valid_q <= 1'b1;
            end else if (take) begin
                valid_q <= 1'b0;
            end
            // Setting events take priority over a simultaneous clear.
            ferr_q <= frame_set | (ferr_q & ~bus.err_clr);
            ovr_q  <= ovr_set   | (ovr_q  & ~bus.err_clr);
        end
    end

    assign bus.rx_data   = data_q;
    assign bus.rx_valid  = valid_q;
    assign bus.frame_err = ferr_q;
    assign bus.overrun   = ovr_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx at CLKS_PER_BIT=10
module tb_uart_rx;
    localparam int C = 10;

    logic clk       = 1'b0;
    logic resetn    = 1'b0;
    logic rx        = 1'b1;
    logic man_ready = 1'b0;
    logic auto_ready = 1'b0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int         at;
        bit         ferr;
        logic [7:0] b;
    } ev_t;
    ev_t evq[$];
    logic [7:0] got[$];

    logic [7:0] m_data  = 8'h00;
    logic       m_valid = 1'b0;
    logic       m_ferr  = 1'b0;
    logic       m_ovr   = 1'b0;

    uart_rx_if bus ();

    uart_rx #(.CLK_FREQ(1000), .BAUD(100)) dut (
        .clk    (clk),
        .resetn (resetn),
        .rx     (rx),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Consumer: manual pulses or, in auto mode, accept each byte as soon as it is seen.
    always @(posedge clk) begin
        #2;
        bus.rx_ready = man_ready | (auto_ready & bus.rx_valid);
        if (auto_ready && bus.rx_valid) got.push_back(bus.rx_data);
    end

    // Frame-level model: each frame produces one outcome at a known edge; the
    // holding register then follows the deliver/consume/overrun rules.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_data  = 8'h00;
            m_valid = 1'b0;
            m_ferr  = 1'b0;
            m_ovr   = 1'b0;
            evq.delete();
        end else begin
            bit dl, fe, so;
            logic [7:0] nb;
            cyc = cyc + 1;
            dl = 0; fe = 0; nb = 8'h00;
            if (evq.size() > 0 && evq[0].at == cyc) begin
                if (evq[0].ferr) fe = 1; else dl = 1;
                nb = evq[0].b;
                void'(evq.pop_front());
            end
            so = dl && m_valid && !bus.rx_ready;
            if (dl && !so) begin
                m_data  = nb;
                m_valid = 1'b1;
            end else if (m_valid && bus.rx_ready) begin
                m_valid = 1'b0;
            end
            if (bus.err_clr) begin
                m_ferr = 1'b0;
                m_ovr  = 1'b0;
            end
            if (fe) m_ferr = 1'b1;
            if (so) m_ovr  = 1'b1;
        end
    end

    always @(negedge clk) begin
        chk("valid", 32'(bus.rx_valid),  32'(m_valid));
        chk("data",  32'(bus.rx_data),   32'(m_data));
        chk("ferr",  32'(bus.frame_err), 32'(m_ferr));
        chk("ovr",   32'(bus.overrun),   32'(m_ovr));
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic hold_bit(input logic v);
        rx = v;
        idle(C);
    endtask

    // Called at posedge+1; the outcome lands 2 sync edges + detection cycle +
    // half a bit to the start centre + 9 bits to the stop centre later.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        ev_t e;
        e.at   = cyc + 3 + C / 2 + 9 * C;
        e.ferr = !stop_bit;
        e.b    = b;
        evq.push_back(e);
        hold_bit(1'b0);
        for (int i = 0; i < 8; i++) hold_bit(b[i]);
        hold_bit(stop_bit);
    endtask

    task automatic pulse_ready();
        man_ready = 1'b1;
        idle(1);
        man_ready = 1'b0;
        idle(2);
    endtask

    task automatic pulse_clr();
        bus.err_clr = 1'b1;
        idle(1);
        bus.err_clr = 1'b0;
        idle(2);
    endtask

    initial begin
        logic [7:0] pb;
        bus.err_clr = 1'b0;
        idle(3);
        chk("reset_valid", 32'(bus.rx_valid),  32'd0);
        chk("reset_data",  32'(bus.rx_data),   32'h00);
        chk("reset_ferr",  32'(bus.frame_err), 32'd0);
        chk("reset_ovr",   32'(bus.overrun),   32'd0);
        resetn = 1'b1;
        idle(5);

        send_frame(8'hA5, 1'b1);
        idle(10);
        chk("a5_data",  32'(bus.rx_data),  32'hA5);
        chk("a5_valid", 32'(bus.rx_valid), 32'd1);
        chk("a5_flags", 32'({bus.frame_err, bus.overrun}), 32'd0);
        pulse_ready();
        chk("a5_taken", 32'(bus.rx_valid), 32'd0);

        auto_ready = 1'b1;
        send_frame(8'h3C, 1'b1);
        send_frame(8'hFF, 1'b1);
        idle(5);
        auto_ready = 1'b0;
        idle(3);
        chk("b2b_count", 32'(got.size()), 32'd2);
        if (got.size() == 2) begin
            chk("b2b_first",  32'(got[0]), 32'h3C);
            chk("b2b_second", 32'(got[1]), 32'hFF);
        end
        chk("b2b_flags", 32'({bus.frame_err, bus.overrun}), 32'd0);

        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        idle(5);
        chk("ovr_data",  32'(bus.rx_data),  32'h11);
        chk("ovr_flag",  32'(bus.overrun),  32'd1);
        chk("ovr_valid", 32'(bus.rx_valid), 32'd1);
        pulse_clr();
        chk("clr_ovr",  32'(bus.overrun), 32'd0);
        chk("clr_data", 32'(bus.rx_data), 32'h11);

        send_frame(8'h55, 1'b0);
        rx = 1'b0;
        idle(30);
        rx = 1'b1;
        idle(20);
        chk("ferr_flag",  32'(bus.frame_err), 32'd1);
        chk("ferr_valid", 32'(bus.rx_valid),  32'd1);
        chk("ferr_data",  32'(bus.rx_data),   32'h11);
        pulse_ready();
        send_frame(8'h0F, 1'b1);
        idle(5);
        chk("after_break", 32'(bus.rx_data), 32'h0F);
        pulse_ready();
        pulse_clr();

        rx = 1'b0;
        idle(3);
        rx = 1'b1;
        idle(20);
        chk("glitch_valid", 32'(bus.rx_valid), 32'd0);
        chk("glitch_flags", 32'({bus.frame_err, bus.overrun}), 32'd0);
        send_frame(8'hC3, 1'b1);
        idle(5);
        chk("post_glitch", 32'(bus.rx_data), 32'hC3);

        pb = 8'h6B;
        hold_bit(1'b0);
        for (int i = 0; i < 4; i++) hold_bit(pb[i]);
        rx = pb[4];
        idle(5);
        resetn = 1'b0;
        #1;
        chk("rst_valid", 32'(bus.rx_valid),  32'd0);
        chk("rst_data",  32'(bus.rx_data),   32'h00);
        chk("rst_flags", 32'({bus.frame_err, bus.overrun}), 32'd0);
        rx = 1'b1;
        idle(4);
        resetn = 1'b1;
        idle(5);
        send_frame(8'h81, 1'b1);
        idle(5);
        chk("rst_recover", 32'(bus.rx_data),  32'h81);
        chk("rst_rvalid",  32'(bus.rx_valid), 32'd1);
        idle(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
